fir_decimator: RTL and testbench

- Downstream stage of FirLowpass. Consumes one 16-bit offset-binary filtered sample per valid cycle.
- Keeps every DECIM-th sample and converts it to two's complement.
- Buffers kept samples in a small FIFO and presents them on a valid/ready interface to the next consumer (logger, DMA or next filter).
- Anti-aliasing is done upstream by the lowpass; this block does no arithmetic filtering.

---
 rtl/fir_pkg.sv | 15 +
 rtl/sync_fifo_fwft.sv | 77 +++++++
 rtl/fir_decimator.sv | 75 +++++++
 tb/tb_fir_decimator.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Sample types and format helpers shared across the FIR chain.
// Pure declarations: no clocked logic, no flow control.
package fir_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic [SAMPLE_W-1:0]        sample_ob_t;
  typedef logic signed [SAMPLE_W-1:0] sample_tc_t;

  // Offset binary to two's complement is an MSB flip; exact, never saturates.
  function automatic sample_tc_t ob_to_tc(input sample_ob_t s);
    return sample_tc_t'({~s[SAMPLE_W-1], s[SAMPLE_W-2:0]});
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a registered head; 1 cycle write-to-out_vld when empty.
// Writes are refused only when full without a same-cycle pop; pop is out_vld && out_rdy.
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_vld,
  input  logic [WIDTH-1:0]       in_dat,
  output logic                   in_rdy,
  output logic                   out_vld,
  output logic [WIDTH-1:0]       out_dat,
  input  logic                   out_rdy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_nxt;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             empty, full, push, pop;

  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == LVL_W'(DEPTH));
    pop      = !empty && out_rdy;
    push     = in_vld && (!full || pop);
    rd_nxt   = rd_ptr_q + 1'b1;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_nxt : rd_ptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Head register holds its last value once the FIFO drains.
    head_d = head_q;
    if (pop && (level_q > LVL_W'(1)))
      head_d = mem_q[rd_nxt];
    else if (push && (empty || pop))
      head_d = in_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push)
      mem_q[wr_ptr_q] <= in_dat;
  end

  assign in_rdy  = !full || pop;
  assign out_vld = !empty;
  assign out_dat = head_q;
  assign level   = level_q;

endmodule

// File: rtl/fir_decimator.sv
// Keeps sample PHASE of every DECIM valid inputs, converts to Q1.15, buffers in a FWFT FIFO; 1 cycle latency.
// No upstream backpressure: a kept sample arriving while full and not popped is dropped and sets sticky overflow.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int DECIM = 4,
  parameter int PHASE = 0,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SAMPLE_W-1:0]    in_sample,
  input  logic                   in_valid,
  output logic [SAMPLE_W-1:0]    out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
);

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  if (DECIM < 1 || DECIM > 256) begin : g_bad_decim
    $error("fir_decimator: DECIM out of range");
  end
  if (PHASE < 0 || PHASE >= DECIM) begin : g_bad_phase
    $error("fir_decimator: PHASE out of range");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fir_decimator: DEPTH must be a power of two >= 2");
  end

  logic [PH_W-1:0] phase_q, phase_d;
  logic            overflow_q, overflow_d;
  logic            keep;
  logic            fifo_in_rdy;
  sample_tc_t      kept_tc;

  always_comb begin
    keep       = in_valid && (phase_q == PH_W'(PHASE));
    kept_tc    = ob_to_tc(sample_ob_t'(in_sample));
    phase_d    = phase_q;
    if (in_valid)
      phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + 1'b1;
    overflow_d = overflow_q || (keep && !fifo_in_rdy);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (keep),
    .in_dat  (kept_tc),
    .in_rdy  (fifo_in_rdy),
    .out_vld (out_valid),
    .out_dat (out_data),
    .out_rdy (out_ready),
    .level   (fifo_level)
  );

  assign overflow = overflow_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Three decimator configurations share one stimulus stream; a queue scoreboard per instance
// checks every pop, level and flag each cycle, alongside directed sequences and a conversion table.
module tb_fir_decimator;

  localparam int DEC[3] = '{4, 4, 1};
  localparam int PH[3]  = '{0, 2, 0};

  logic        clk;
  logic        reset;
  logic [15:0] in_sample;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] od[3];
  logic        ov[3];
  logic [3:0]  lvl[3];
  logic        of[3];

  typedef logic [15:0] q_t[$];
  q_t sb[3];
  int m_cnt[3];
  bit m_ovf[3];
  bit chk_en;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] s;
    logic [15:0] e;
  } vec_t;
  vec_t tbl[5];

  fir_decimator #(.DECIM(4), .PHASE(0), .DEPTH(8)) u_dut0 (
    .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .fifo_level(lvl[0]), .overflow(of[0]));

  fir_decimator #(.DECIM(4), .PHASE(2), .DEPTH(8)) u_dut1 (
    .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .fifo_level(lvl[1]), .overflow(of[1]));

  fir_decimator #(.DECIM(1), .PHASE(0), .DEPTH(8)) u_dut2 (
    .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid),
    .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready),
    .fifo_level(lvl[2]), .overflow(of[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Scoreboard: state compared at negedge, then advanced for the coming edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("level%0d", i), 32'(lvl[i]), 32'(sb[i].size()));
        check($sformatf("out_valid%0d", i), 32'(ov[i]), 32'(sb[i].size() != 0));
        check($sformatf("overflow%0d", i), 32'(of[i]), 32'(m_ovf[i]));
        if (reset) begin
          sb[i].delete();
          m_cnt[i] = 0;
          m_ovf[i] = 1'b0;
        end else begin
          if (sb[i].size() != 0 && out_ready)
            check($sformatf("pop_data%0d", i), 32'(od[i]), 32'(sb[i].pop_front()));
          if (in_valid) begin
            if (m_cnt[i] == PH[i]) begin
              if (sb[i].size() < 8) sb[i].push_back(in_sample ^ 16'h8000);
              else m_ovf[i] = 1'b1;
            end
            m_cnt[i] = (m_cnt[i] == DEC[i] - 1) ? 0 : m_cnt[i] + 1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{s: 16'h0000, e: 16'h8000};
    tbl[1] = '{s: 16'hFFFF, e: 16'h7FFF};
    tbl[2] = '{s: 16'h8000, e: 16'h0000};
    tbl[3] = '{s: 16'h7FFF, e: 16'hFFFF};
    tbl[4] = '{s: 16'h1234, e: 16'h9234};

    chk_en    = 1'b0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sample = 16'h0000;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
    end
    step();
    step();
    chk_en = 1'b1;
    reset  = 1'b0;

    // Reset state
    check("rst_out_data", 32'(od[0]), 32'h0);
    check("rst_out_valid", 32'(ov[0]), 32'h0);
    check("rst_level", 32'(lvl[0]), 32'h0);
    check("rst_overflow", 32'(of[0]), 32'h0);

    // Ramp, DECIM=4 PHASE=0
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_sample = 16'h8000 + 16'(k);
      in_valid  = 1'b1;
      step();
      check($sformatf("ramp_valid%0d", k), 32'(ov[0]), 32'((k % 4) == 0));
      if ((k % 4) == 0) check($sformatf("ramp_data%0d", k), 32'(od[0]), 32'(k));
    end
    in_valid = 1'b0;
    step();
    check("ramp_overflow", 32'(of[0]), 32'h0);

    // Gapped valid, PHASE=2
    do_reset();
    for (int j = 1; j <= 8; j++) begin
      in_sample = 16'h8000 + 16'(j);
      in_valid  = 1'b1;
      step();
      check($sformatf("gap_valid%0d", j), 32'(ov[1]), 32'(j == 3 || j == 7));
      if (j == 3 || j == 7) check($sformatf("gap_data%0d", j), 32'(od[1]), 32'(j));
      in_valid = 1'b0;
      step();
    end

    // Backpressure and overflow, DECIM=1
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_sample = 16'h9000 + 16'(k);
      in_valid  = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("bp_level", 32'(lvl[2]), 32'd8);
    check("bp_overflow", 32'(of[2]), 32'h1);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("bp_valid%0d", k), 32'(ov[2]), 32'h1);
      check($sformatf("bp_data%0d", k), 32'(od[2]), 32'h1000 + 32'(k));
      step();
    end
    check("bp_empty", 32'(ov[2]), 32'h0);

    // Full with simultaneous push and pop
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_sample = 16'hA000 + 16'(k);
      in_valid  = 1'b1;
      step();
    end
    in_sample = 16'hA008;
    out_ready = 1'b1;
    check("full_head", 32'(od[2]), 32'h2000);
    step();
    in_valid = 1'b0;
    check("full_level", 32'(lvl[2]), 32'd8);
    check("full_overflow", 32'(of[2]), 32'h0);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("full_data%0d", k), 32'(od[2]), 32'h2000 + 32'(k));
      step();
    end
    check("full_drained", 32'(ov[2]), 32'h0);

    // Conversion extremes, table-driven
    for (int i = 0; i < 5; i++) begin
      in_sample = tbl[i].s;
      in_valid  = 1'b1;
      step();
      check($sformatf("conv_valid%0d", i), 32'(ov[2]), 32'h1);
      check($sformatf("conv_data%0d", i), 32'(od[2]), 32'(tbl[i].e));
    end
    in_valid = 1'b0;
    step();

    // Reset mid-stream
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_sample = 16'h9000 + 16'(k);
      in_valid  = 1'b1;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();
    out_ready = 1'b0;
    check("mid_level", 32'(lvl[2]), 32'd5);
    check("mid_overflow", 32'(of[2]), 32'h1);
    do_reset();
    check("mid_rst_level", 32'(lvl[2]), 32'h0);
    check("mid_rst_valid", 32'(ov[2]), 32'h0);
    check("mid_rst_overflow", 32'(of[2]), 32'h0);
    check("mid_rst_data", 32'(od[2]), 32'h0);
    in_sample = 16'hC123;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("mid_first_valid", 32'(ov[0]), 32'h1);
    check("mid_first_data", 32'(od[0]), 32'h4123);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
